// File: rtl/yutorina_if_prefetch_pkg.sv
// Shared CPU definitions for the yutorina core.
// Active-low valid levels and default fetch geometry.
package yutorina_if_prefetch_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

endpackage

// File: rtl/yutorina_sync_fifo.sv
// Single-clock FIFO with synchronous clear.
// Simultaneous push/pop is legal at full and at empty.
module yutorina_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_we;
  logic             w_re;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];

  assign w_we = i_push & (~o_full | i_pop);
  assign w_re = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + PW'(1);
      if (w_re) r_rp <= r_rp + PW'(1);
      unique case ({w_we, w_re})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/yutorina_if_prefetch.sv
// Instruction prefetch stage: credit-based fetch queue
// with in-order response tracking and branch flush.
module yutorina_if_prefetch
  import yutorina_if_prefetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = ADDR_W_DEF,
  parameter int unsigned         DATA_W   = DATA_W_DEF,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en_,
  output logic              busy
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned QW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_rpc;
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_disc;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_insn;
  logic              r_en_;

  logic [CW-1:0]     w_cnt;
  logic [CW:0]       w_sum;
  logic [CW-1:0]     w_out_nx;
  logic              w_full;
  logic              w_empty;
  logic              w_grant;
  logic              w_resp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [QW-1:0]     w_head;

  // Queued words plus in-flight requests never exceed DEPTH,
  // so every accepted response is guaranteed a slot.
  assign w_sum   = {1'b0, w_cnt} + {1'b0, r_out};
  assign mem_req = ~rst & ~br_taken & (w_sum < (CW+1)'(DEPTH));
  assign mem_addr = r_fpc;

  assign w_grant = mem_req & mem_gnt;
  assign w_resp  = mem_rvalid & (r_out != '0);
  assign w_drop  = w_resp & (r_disc != '0);
  assign w_push  = w_resp & (r_disc == '0) & ~br_taken
                 & (~w_full | w_pop);
  assign w_pop   = ~stall & ~w_empty & ~br_taken;

  assign w_out_nx = r_out + CW'(w_grant) - CW'(w_resp);

  assign busy = ~rst & w_empty & ((r_out != '0) | mem_req);

  assign if_pc   = r_pc;
  assign if_insn = r_insn;
  assign if_en_  = r_en_;

  yutorina_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (br_taken),
    .i_wdata ({r_rpc, mem_rdata}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc  <= RESET_PC;
      r_rpc  <= RESET_PC;
      r_out  <= '0;
      r_disc <= '0;
    end else begin
      r_out <= w_out_nx;
      if (br_taken) begin
        r_fpc  <= br_addr;
        r_rpc  <= br_addr;
        r_disc <= w_out_nx;
      end else begin
        if (w_grant) r_fpc  <= r_fpc + ADDR_W'(1);
        if (w_push)  r_rpc  <= r_rpc + ADDR_W'(1);
        if (w_drop)  r_disc <= r_disc - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_insn <= '0;
      r_en_  <= DISABLE_;
    end else if (br_taken) begin
      r_en_  <= DISABLE_;
    end else if (!stall) begin
      if (!w_empty) begin
        r_pc   <= w_head[QW-1:DATA_W];
        r_insn <= w_head[DATA_W-1:0];
        r_en_  <= ENABLE_;
      end else begin
        r_en_  <= DISABLE_;
      end
    end
  end

endmodule

// File: tb/tb_yutorina_if_prefetch.sv
// Directed bench for yutorina_if_prefetch with a
// zero-wait in-order memory responder.
module tb_yutorina_if_prefetch;

  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RPC = 30'h100;

  logic          clk;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b1;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_en_;
  logic          busy;

  logic          rsp_en = 1'b1;
  logic          force_rv = 1'b0;
  logic [AW-1:0] pend [$];

  int n_tests = 0;
  int n_fail  = 0;

  yutorina_if_prefetch #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en_     (if_en_),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] insn_of(input logic [AW-1:0] a);
    return {2'b11, a} ^ 32'h0000_5A5A;
  endfunction

  // Memory: answers each grant one cycle later, in order.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_rvalid && pend.size() != 0) void'(pend.pop_front());
      if (mem_req && mem_gnt) pend.push_back(mem_addr);
    end
    #1;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end else if (rsp_en && !rst && pend.size() != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = insn_of(pend[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_addr = '0;
    mem_gnt = 1'b1; rsp_en = 1'b1; force_rv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0;
    mem_gnt = 1'b1; rsp_en = 1'b1; force_rv = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL rst_en got=%0b exp=1", if_en_); end
    n_tests++; if (if_pc !== RPC) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", if_pc, RPC); end
    n_tests++; if (if_insn !== '0) begin n_fail++; $display("FAIL rst_insn got=%h exp=0", if_insn); end
    rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rel_mem_req got=%0b exp=1", mem_req); end
    n_tests++; if (mem_addr !== RPC) begin n_fail++; $display("FAIL rel_addr got=%h exp=%h", mem_addr, RPC); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rel_busy got=%0b exp=1", busy); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL zw_n1_en got=%0b exp=1", if_en_); end
    n_tests++; if (mem_addr !== RPC + 30'd1) begin n_fail++; $display("FAIL zw_n1_addr got=%h exp=%h", mem_addr, RPC + 30'd1); end
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL zw_n2_en got=%0b exp=1", if_en_); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== 1'b0) begin n_fail++; $display("FAIL zw_en[%0d] got=%0b exp=0", i, if_en_); end
      n_tests++; if (if_pc !== RPC + AW'(i)) begin n_fail++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, if_pc, RPC + AW'(i)); end
      n_tests++; if (if_insn !== insn_of(RPC + AW'(i))) begin n_fail++; $display("FAIL zw_insn[%0d] got=%h exp=%h", i, if_insn, insn_of(RPC + AW'(i))); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL st_mem_req got=%0b exp=0", mem_req); end
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL st_en got=%0b exp=1", if_en_); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy got=%0b exp=0", busy); end
    n_tests++; if (mem_addr !== RPC + 30'd4) begin n_fail++; $display("FAIL st_addr got=%h exp=%h", mem_addr, RPC + 30'd4); end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== 1'b0) begin n_fail++; $display("FAIL st_out_en[%0d] got=%0b exp=0", i, if_en_); end
      n_tests++; if (if_pc !== RPC + AW'(i)) begin n_fail++; $display("FAIL st_out_pc[%0d] got=%h exp=%h", i, if_pc, RPC + AW'(i)); end
    end
  endtask

  task automatic test_branch();
    int k;
    do_reset();
    rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (mem_addr !== RPC + 30'd3) begin n_fail++; $display("FAIL br_pre_addr got=%h exp=%h", mem_addr, RPC + 30'd3); end
    br_taken = 1'b1;
    br_addr  = 30'h40;
    @(negedge clk);
    br_taken = 1'b0;
    rsp_en   = 1'b1;
    #1;
    n_tests++; if (mem_addr !== 30'h40) begin n_fail++; $display("FAIL br_addr got=%h exp=40", mem_addr); end
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL br_en got=%0b exp=1", if_en_); end
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_en_ === 1'b0) break;
    end
    n_tests++; if (k != 5) begin n_fail++; $display("FAIL br_latency got=%0d exp=5", k); end
    n_tests++; if (if_pc !== 30'h40) begin n_fail++; $display("FAIL br_first_pc got=%h exp=40", if_pc); end
    n_tests++; if (if_insn !== insn_of(30'h40)) begin n_fail++; $display("FAIL br_first_insn got=%h exp=%h", if_insn, insn_of(30'h40)); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== 1'b0 || if_pc !== 30'h40 + AW'(i)) begin n_fail++; $display("FAIL br_seq[%0d] got=%0b/%h exp=0/%h", i, if_en_, if_pc, 30'h40 + AW'(i)); end
    end
  endtask

  task automatic test_gnt_hold();
    logic [2:0] en_exp;
    do_reset();
    repeat (2) @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b0 || if_pc !== RPC) begin n_fail++; $display("FAIL gh_pc0 got=%0b/%h exp=0/%h", if_en_, if_pc, RPC); end
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b0 || if_pc !== RPC + 30'd1) begin n_fail++; $display("FAIL gh_pc1 got=%0b/%h exp=0/%h", if_en_, if_pc, RPC + 30'd1); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gh_busy[%0d] got=%0b exp=1", i, busy); end
      n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL gh_en[%0d] got=%0b exp=1", i, if_en_); end
      n_tests++; if (mem_addr !== RPC + 30'd2) begin n_fail++; $display("FAIL gh_addr[%0d] got=%h exp=%h", i, mem_addr, RPC + 30'd2); end
    end
    mem_gnt = 1'b1;
    en_exp  = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== en_exp[i]) begin n_fail++; $display("FAIL gh_resume_en[%0d] got=%0b exp=%0b", i, if_en_, en_exp[i]); end
    end
    n_tests++; if (if_pc !== RPC + 30'd2) begin n_fail++; $display("FAIL gh_resume_pc got=%h exp=%h", if_pc, RPC + 30'd2); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] top_a;
    top_a = '1;
    do_reset();
    br_taken = 1'b1;
    br_addr  = top_a;
    @(negedge clk);
    br_taken = 1'b0;
    #1;
    n_tests++; if (mem_addr !== top_a || mem_req !== 1'b1) begin n_fail++; $display("FAIL wr_addr0 got=%h/%0b exp=%h/1", mem_addr, mem_req, top_a); end
    @(negedge clk);
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL wr_addr1 got=%h exp=0", mem_addr); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== 1'b0 || if_pc !== top_a + AW'(i)) begin n_fail++; $display("FAIL wr_pc[%0d] got=%0b/%h exp=0/%h", i, if_en_, if_pc, top_a + AW'(i)); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    stall = 1'b1;
    repeat (2) @(negedge clk);
    rsp_en = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mr_credit got=%0b exp=0", mem_req); end
    rst      = 1'b1;
    force_rv = 1'b1;
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL mr_en got=%0b exp=1", if_en_); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mr_mem_req got=%0b exp=0", mem_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got=%0b exp=0", busy); end
    n_tests++; if (if_pc !== RPC || if_insn !== '0) begin n_fail++; $display("FAIL mr_out got=%h/%h exp=%h/0", if_pc, if_insn, RPC); end
    rst = 1'b0; force_rv = 1'b0; stall = 1'b0; rsp_en = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mr_req_after got=%0b exp=1", mem_req); end
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (if_en_ !== 1'b1) begin n_fail++; $display("FAIL mr_stale_en got=%0b/%h exp=1", if_en_, if_insn); end
    end
    @(negedge clk);
    n_tests++; if (if_en_ !== 1'b0 || if_pc !== RPC) begin n_fail++; $display("FAIL mr_first got=%0b/%h exp=0/%h", if_en_, if_pc, RPC); end
    n_tests++; if (if_insn !== insn_of(RPC)) begin n_fail++; $display("FAIL mr_insn got=%h exp=%h", if_insn, insn_of(RPC)); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch();
    test_gnt_hold();
    test_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
